// File: rtl/mem_resp_types.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// counter width, LFSR seed/taps and the byte-lane merge used on write commit.
package mem_resp_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wide enough for LATENCY-1 (max 14) plus the random extra delay (max 3).
    localparam int CNT_W = 5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Replace only the byte lanes selected by mask.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying a 0..3 cycle extra response
// delay. Only instantiated when MEM_RESP_RANDOM_LAT_EN is defined.
module mem_resp_lfsr
    import mem_resp_types::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] extra_dly
);

    logic [15:0] lfsr;
    logic        fb;

    assign fb        = ^(lfsr & LFSR_TAPS);
    assign extra_dly = lfsr[1:0];

    // Advance the sequence every cycle; reseed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write request at a time, answers after a
// fixed latency with a one-cycle mem_resp pulse, backed by a word array.
// Optional feature: define MEM_RESP_RANDOM_LAT_EN to add 0..3 cycles of
// pseudo-random extra latency per request.
module mem_responder
    import mem_resp_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  load_val;
    logic [1:0]        extra_dly;
    logic              req;
    logic              capture;

    logic [IDX_W-1:0]  idx_p0;
    logic [3:0]        wmask_p0;
    logic [31:0]       wdata_p0;
    logic              wr_p0;

    logic [31:0]       mem [DEPTH_WORDS];

    // Address bits outside the word index are intentionally ignored.
    logic              unused_addr;
    assign unused_addr = ^{mem_addr[31:IDX_W+2], mem_addr[1:0]};

`ifdef MEM_RESP_RANDOM_LAT_EN
    mem_resp_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .extra_dly (extra_dly)
    );
`else
    assign extra_dly = 2'd0;
`endif

    assign req      = |(mem_rmask | mem_wmask);
    assign capture  = (state == IDLE) && req;
    assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(extra_dly);

    // Next-state logic: a zero load skips WAIT, WAIT leaves when the count expires.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = load_val;
                    state_nxt = (load_val == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture stage (p0): request fields frozen when the request is accepted.
    always_ff @(posedge clk) begin
        if (capture) begin
            idx_p0   <= mem_addr[IDX_W+1:2];
            wmask_p0 <= mem_wmask;
            wdata_p0 <= mem_wdata;
            wr_p0    <= |mem_wmask;
        end
    end

    // Sticky error for requests carrying both read and write masks.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (capture && (|mem_rmask) && (|mem_wmask)) begin
            err <= 1'b1;
        end
    end

    // Write commit in the response cycle; a reset in that cycle aborts it.
    always_ff @(posedge clk) begin
        if (!rst && (state == RESP) && wr_p0) begin
            mem[idx_p0] <= merge_bytes(mem[idx_p0], wdata_p0, wmask_p0);
        end
    end

    assign mem_resp  = (state == RESP);
    assign busy      = (state != IDLE);
    assign mem_rdata = ((state == RESP) && !wr_p0) ? mem[idx_p0] : 32'd0;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, number of 32-bit words in the backing array (power of two).
REQ-002 Parameter LATENCY, 2, base cycles from request capture to mem_resp (legal range 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  input  32  byte address from the initiator; bits [1:0] ignored.
REQ-006 mem_rmask  input  4  read byte mask; nonzero marks a read request.
REQ-007 mem_wmask  input  4  write byte mask; nonzero marks a write request.
REQ-008 mem_wdata  input  32  write data, byte lanes aligned to the word.
REQ-009 mem_rdata  output  32  read data, valid only in the mem_resp cycle.
REQ-010 mem_resp  output  1  one-cycle completion pulse per accepted request.
REQ-011 busy  output  1  high in WAIT and RESP states.
REQ-012 err  output  1  sticky flag for illegal requests.

Function
REQ-013 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-014 Request seen in IDLE when (mem_rmask | mem_wmask) != 0; responder captures addr, masks and wdata that cycle (T).
REQ-015 Capture loads down-counter with LATENCY-1 (plus extra delay, REQ-027); LATENCY=1 goes directly to RESP.
REQ-016 WAIT decrements counter each cycle; counter==0 -> RESP.
REQ-017 RESP: mem_resp=1 for exactly one cycle, earliest cycle T+LATENCY; next state IDLE.
REQ-018 Inputs ignored in WAIT and RESP; initiator holds them stable, and no new request is accepted in the RESP cycle.
REQ-019 First cycle after RESP is IDLE; a nonzero mask then is a new request (back-to-back throughput one request per LATENCY+1 cycles).
REQ-020 Word index = captured addr[31:2] modulo DEPTH_WORDS (address wraps, no out-of-range error).
REQ-021 Read: mem_rdata = full stored word regardless of rmask; initiator extracts bytes.
REQ-022 Write: only bytes with wmask[i]=1 updated; commit in RESP cycle; mem_rdata in write RESP cycle = 0.
REQ-023 rmask and wmask both nonzero: treated as write, err set to 1 and held until rst.
REQ-024 mem_rdata = 0 and mem_resp = 0 in every non-RESP cycle.

Reset
REQ-025 rst forces IDLE, counter 0, mem_resp 0, mem_rdata 0, busy 0, err 0 in the following cycle.
REQ-026 rst mid-operation aborts the pending request: no write commit, no mem_resp; array contents are not cleared by reset.

Configuration
REQ-027 MEM_RESP_RANDOM_LAT_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on rst, advances every cycle; at capture, extra delay = lfsr[1:0] (0..3) added to counter.
REQ-028 MEM_RESP_RANDOM_LAT_EN undefined: no LFSR logic; latency exactly LATENCY for every request.

Structure
REQ-029 Shared package mem_resp_types holds state enum, LFSR seed and tap constants.
REQ-030 One sub-module mem_resp_lfsr (instantiated only under MEM_RESP_RANDOM_LAT_EN); array inferred in mem_responder as plain register array.

Verification
REQ-031 LATENCY=2, macro off: write addr 0x10, wmask 4'hF, wdata 0xDEADBEEF at T -> mem_resp at T+2; read addr 0x10 -> rdata 0xDEADBEEF with resp at read-T+2.
REQ-032 Byte mask: word holds 0x11223344, write wmask 4'b0101 wdata 0xAABBCCDD -> subsequent read 0x11BB33DD.
REQ-033 Wrap: DEPTH_WORDS=1024, write 0x00001004 value 0x5A5A5A5A, read 0x00000004 -> 0x5A5A5A5A; addr[1:0]=2'b11 gives same word.
REQ-034 Back-to-back: request held through resp, new request issued in cycle after resp -> exactly one mem_resp per request, no duplicate accept.
REQ-035 Reset mid-WAIT on write to 0x20 -> no mem_resp, busy 0 next cycle, later read of 0x20 returns prior value.
REQ-036 Illegal rmask=4'hF, wmask=4'h1 -> treated as write, err=1 sticky until rst; macro on: every latency in LATENCY..LATENCY+3 over 1000 requests.
